// File: rtl/alu_shift_seq.sv
// alu_shift_seq: sequential ALU / shifter with a valid-ready command and response.
//   CLK, rst_n             : clock, synchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake (ready only while IDLE)
//   cmd_kind               : 0 = ALU command, 1 = shift command
//   invertA/invertB        : invert ALU operands (ignored by LESS)
//   operation              : ALU opcode (ADD/AND/OR/LESS parameters)
//   aluSrc1/aluSrc2        : ALU operands
//   leftRight/shamt/sftSrc : shift direction, amount, operand
//   rsp_valid/rsp_ready    : response handshake (valid only while RESP)
//   result/zero/overflow   : registered response data and flags
module alu_shift_seq #(
    parameter logic [1:0] ADD         = 2'b10,
    parameter logic [1:0] AND         = 2'b01,
    parameter logic [1:0] OR          = 2'b00,
    parameter logic [1:0] LESS        = 2'b11,
    parameter logic       SHIFT_RIGHT = 1'b1
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_kind,
    input  logic        invertA,
    input  logic        invertB,
    input  logic [1:0]  operation,
    input  logic [31:0] aluSrc1,
    input  logic [31:0] aluSrc2,
    input  logic        leftRight,
    input  logic [4:0]  shamt,
    input  logic [31:0] sftSrc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALU,
        S_SHIFT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic            inv_a_q, inv_a_d;
    logic            inv_b_q, inv_b_d;
    logic [1:0]      op_q, op_d;
    logic [DW-1:0]   src1_q, src1_d;
    logic [DW-1:0]   src2_q, src2_d;
    logic            dir_q, dir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   work_q, work_d;
    logic [DW-1:0]   result_q, result_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic [DW-1:0]   alu_a, alu_b, alu_sum, alu_res, shifted;
    logic            less;

    // Datapath helpers working on the captured command.
    assign alu_a   = inv_a_q ? ~src1_q : src1_q;
    assign alu_b   = inv_b_q ? ~src2_q : src2_q;
    // Carry-in of invertB turns A + ~B into A - B.
    assign alu_sum = alu_a + alu_b + DW'(inv_b_q);
    // LESS compares the raw operands, independent of the invert bits.
    assign less    = $signed(src1_q) < $signed(src2_q);
    assign shifted = (dir_q == SHIFT_RIGHT) ? (work_q >> 1) : (work_q << 1);

    // ALU result select.
    always_comb begin
        alu_res = '0;
        if (op_q == ADD) begin
            alu_res = alu_sum;
        end else if (op_q == AND) begin
            alu_res = alu_a & alu_b;
        end else if (op_q == OR) begin
            alu_res = alu_a | alu_b;
        end else if (op_q == LESS) begin
            alu_res = {{(DW-1){1'b0}}, less};
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        inv_a_d     = inv_a_q;
        inv_b_d     = inv_b_q;
        op_d        = op_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    inv_a_d = invertA;
                    inv_b_d = invertB;
                    op_d    = operation;
                    src1_d  = aluSrc1;
                    src2_d  = aluSrc2;
                    dir_d   = leftRight;
                    cnt_d   = shamt;
                    work_d  = sftSrc;
                    state_d = cmd_kind ? S_SHIFT : S_ALU;
                end
            end
            S_ALU: begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                ovf_d    = (op_q == ADD) && (alu_a[DW-1] == alu_b[DW-1])
                           && (alu_sum[DW-1] != alu_a[DW-1]);
                state_d  = S_RESP;
            end
            S_SHIFT: begin
                // Count 0 means a single pass-through cycle with no shift.
                if (cnt_q <= CW'(1)) begin
                    result_d = (cnt_q == '0) ? work_q : shifted;
                    zero_d   = (((cnt_q == '0) ? work_q : shifted) == '0);
                    ovf_d    = 1'b0;
                    state_d  = S_RESP;
                end else begin
                    work_d = shifted;
                    cnt_d  = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            inv_a_q     <= 1'b0;
            inv_b_q     <= 1'b0;
            op_q        <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            work_q      <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inv_a_q     <= inv_a_d;
            inv_b_q     <= inv_b_d;
            op_q        <= op_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule
